// File: rtl/mico_pkg.sv
// rtl/mico_pkg.sv - shared types and constants for the iterative multiplier
package mico_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mul_state_t;

   localparam int MUL_ITERS = 32;

   function automatic logic a_is_signed(input mul_op_t op);
      return op != MULHU;
   endfunction

   function automatic logic b_is_signed(input mul_op_t op);
      return (op == MUL) || (op == MULH);
   endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// rtl/mul_seq_dp.sv - shift-add datapath: magnitude capture, accumulate, sign fix-up
// Exposes the early-exit condition used when MUL_EARLY_EXIT_EN is defined.
module mul_seq_dp
   import mico_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  mul_op_t         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            valid,
   output logic            last_bit,
   output logic [XLEN-1:0] result
);

   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic              neg;
   mul_op_t           op_r;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] p;

   assign a_neg = a_is_signed(op) & a[XLEN-1];
   assign b_neg = b_is_signed(op) & b[XLEN-1];
   // two's-complement negate; the most negative value maps to itself as unsigned
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         op_r   <= MUL;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{XLEN{1'b0}}, a_mag};
         mplier <= b_mag;
         neg    <= a_neg ^ b_neg;
         op_r   <= op;
      end else if (step) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

   // true on the step whose shift leaves the multiplier empty
   assign last_bit = (mplier[XLEN-1:1] == '0);

   assign p      = neg ? (~acc + 1'b1) : acc;
   assign result = !valid          ? '0 :
                   (op_r == MUL)   ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - RV32M iterative multiplier top: FSM, counter, handshakes, flush
// Optional MUL_EARLY_EXIT_EN ends iteration once the remaining multiplier bits are zero.
module mul_seq
   import mico_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  mul_op_t         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   mul_state_t state;
   logic [5:0] cnt;
   logic       accept;
   logic       step;
   logic       last_bit;
   logic       last_iter;

   assign accept = (state == IDLE) && in_valid && in_ready && !flush;
   assign step   = (state == BUSY) && !flush;

`ifdef MUL_EARLY_EXIT_EN
   // the counter bound is redundant here but keeps the exit unconditional
   assign last_iter = last_bit || (cnt == 6'(MUL_ITERS - 1));
`else
   assign last_iter = (cnt == 6'(MUL_ITERS - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state    <= BUSY;
                  in_ready <= 1'b0;
                  cnt      <= '0;
               end
            end
            BUSY: begin
               cnt <= cnt + 6'd1;
               if (last_iter) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   mul_seq_dp #(.XLEN(XLEN)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .step     (step),
      .op       (op),
      .a        (a),
      .b        (b),
      .valid    (out_valid),
      .last_bit (last_bit),
      .result   (result)
   );

endmodule
